// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - shared constants for the ALU issue controller
package alu_ctrl_pkg;

    localparam int INSTR_W = 20;
    localparam int OPC_W   = 4;
    localparam int DATA_W  = 8;
    localparam int OPC_MSB = 19;
    localparam int A_MSB   = 15;
    localparam int B_MSB   = 7;

    localparam logic [OPC_W-1:0] HALT_OP = 4'b1111;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_EXEC  = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

endpackage

// File: rtl/alu_ctrl_decode.sv
// rtl/alu_ctrl_decode.sv - splits an instruction word into ALU fields and flags HALT
module alu_ctrl_decode
    import alu_ctrl_pkg::*;
#(
    parameter logic [OPC_W-1:0] HALT_OP = 4'b1111
) (
    input  logic [INSTR_W-1:0] i_instr,
    output logic [OPC_W-1:0]   o_opcode,
    output logic [DATA_W-1:0]  o_operand_a,
    output logic [DATA_W-1:0]  o_operand_b,
    output logic               o_is_halt
);

    assign o_opcode    = i_instr[OPC_MSB -: OPC_W];
    assign o_operand_a = i_instr[A_MSB -: DATA_W];
    assign o_operand_b = i_instr[B_MSB -: DATA_W];
    assign o_is_halt   = (o_opcode == HALT_OP);

endmodule

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - fetches instructions from ROM, issues them to the ALU, streams results out
module alu_issue_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int               ADDR_W  = 4,
    parameter logic [OPC_W-1:0] HALT_OP = 4'b1111
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               imem_rd_en,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [OPC_W-1:0]   opcode,
    output logic [DATA_W-1:0]  operand_A,
    output logic [DATA_W-1:0]  operand_B,
    input  logic [DATA_W-1:0]  result,
    input  logic [2:0]         flag,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [DATA_W-1:0]  res_data,
    output logic [2:0]         res_flag,
    output logic [ADDR_W-1:0]  res_addr,
    output logic [2:0]         flag_sticky,
    output logic               busy,
    output logic               done
);

    localparam logic [ADDR_W-1:0] PC_LAST = '1;
    localparam logic [ADDR_W-1:0] PC_ONE  = 1;

    logic [2:0]        r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [OPC_W-1:0]  r_opcode;
    logic [DATA_W-1:0] r_operand_a;
    logic [DATA_W-1:0] r_operand_b;
    logic              r_res_valid;
    logic [DATA_W-1:0] r_res_data;
    logic [2:0]        r_res_flag;
    logic [ADDR_W-1:0] r_res_addr;
    logic [2:0]        r_flag_sticky;
    logic              r_busy;
    logic              r_done;

    logic [OPC_W-1:0]  w_opcode;
    logic [DATA_W-1:0] w_operand_a;
    logic [DATA_W-1:0] w_operand_b;
    logic              w_is_halt;

    alu_ctrl_decode #(
        .HALT_OP (HALT_OP)
    ) u_decode (
        .i_instr     (imem_data),
        .o_opcode    (w_opcode),
        .o_operand_a (w_operand_a),
        .o_operand_b (w_operand_b),
        .o_is_halt   (w_is_halt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_pc          <= '0;
            r_opcode      <= '0;
            r_operand_a   <= '0;
            r_operand_b   <= '0;
            r_res_valid   <= 1'b0;
            r_res_data    <= '0;
            r_res_flag    <= '0;
            r_res_addr    <= '0;
            r_flag_sticky <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_pc          <= '0;
                        r_flag_sticky <= '0;
                        r_done        <= 1'b0;
                        r_busy        <= 1'b1;
                        r_state       <= S_FETCH;
                    end
                end
                S_FETCH: r_state <= S_WAIT;
                S_WAIT: begin
                    // HALT leaves the ALU inputs showing the last real instruction
                    if (w_is_halt) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_opcode    <= w_opcode;
                        r_operand_a <= w_operand_a;
                        r_operand_b <= w_operand_b;
                        r_state     <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_res_data  <= result;
                    r_res_flag  <= flag;
                    r_res_addr  <= r_pc;
                    r_res_valid <= 1'b1;
                    r_state     <= S_RESP;
                end
                S_RESP: begin
                    if (res_ready) begin
                        r_res_valid   <= 1'b0;
                        r_flag_sticky <= r_flag_sticky | r_res_flag;
                        if (r_pc == PC_LAST) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_pc    <= r_pc + PC_ONE;
                            r_state <= S_FETCH;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign imem_rd_en  = (r_state == S_FETCH);
    assign imem_addr   = r_pc;
    assign opcode      = r_opcode;
    assign operand_A   = r_operand_a;
    assign operand_B   = r_operand_b;
    assign res_valid   = r_res_valid;
    assign res_data    = r_res_data;
    assign res_flag    = r_res_flag;
    assign res_addr    = r_res_addr;
    assign flag_sticky = r_flag_sticky;
    assign busy        = r_busy;
    assign done        = r_done;

endmodule
